mips_uart_rx: RTL and testbench
===============================

MIPS_UART_RX -- requirements
Module: mips_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-005 SHALL have port data_out  output  8  last correctly received byte; feeds the MIPS input register data_in.
REQ-006 SHALL have port data_valid  output  1  one-cycle pulse when data_out is updated; feeds the input register write enable.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse on a parity mismatch (see Configuration).
REQ-009 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP; one bit-cycle counter of width clog2(CLKS_PER_BIT), one 3-bit bit index.
REQ-012 IDLE -> START on rx_s == 0; counter cleared.
REQ-013 START: at count CLKS_PER_BIT/2 - 1 (integer division), sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch, no error pulse).
REQ-014 DATA: sample rx_s at count CLKS_PER_BIT - 1 into shift register bit[index], LSB first; after bit 7 -> PARITY if enabled, else STOP.
REQ-015 STOP: sample at count CLKS_PER_BIT - 1; 1 -> load data_out and pulse data_valid the next cycle, unless a parity error was latched for this frame; 0 -> pulse frame_err, data_out unchanged.
REQ-016 STOP -> IDLE after its sample in all cases; a new frame SHALL NOT begin until rx_s is seen high in IDLE (break/low line produces exactly one frame_err).
REQ-017 data_valid, frame_err and parity_err SHALL each be high for exactly one clk cycle per event and SHALL never be high simultaneously.
REQ-018 Latency: data_valid SHALL rise exactly 1 clk after the stop-bit sample edge; data_out SHALL be stable from that cycle until the next data_valid.
REQ-019 Back-to-back frames (start bit immediately after the stop bit) SHALL be received without loss.

Reset
REQ-020 On rst high at a clk edge: state IDLE, counters 0, synchronizer flops 1, data_out 8'h00, data_valid/frame_err/parity_err/busy 0.
REQ-021 rst asserted mid-frame SHALL abort the frame with no output pulse; reception resumes on the first start bit after rst deasserts and rx_s is seen high.

Configuration
REQ-022 Macro UART_RX_PARITY_EN defined: PARITY state inserted between DATA and STOP; one even-parity bit sampled at count CLKS_PER_BIT - 1; mismatch -> parity_err pulse 1 clk after the stop-bit sample, no data_valid, data_out unchanged.
REQ-023 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is 10 bits, parity_err tied to 0.
REQ-024 A frame with both a parity mismatch and a bad stop bit SHALL report frame_err only.

Verification (CLKS_PER_BIT = 8)
REQ-025 Frame 0x5A, valid stop -> data_out = 8'h5A, one data_valid pulse 1 clk after the stop sample, busy low thereafter.
REQ-026 Frames 0x00, 0xFF, 0xA5 back-to-back -> three data_valid pulses, data_out sequence 00, FF, A5.
REQ-027 rx low for 3 clks then high (glitch) -> returns to IDLE, no pulses, data_out unchanged.
REQ-028 Frame 0x3C with stop bit 0 -> one frame_err pulse, no data_valid, data_out keeps previous value.
REQ-029 rst pulsed after data bit 4 of frame 0x81, then frame 0x42 -> no output for 0x81, data_out = 8'h42.
REQ-030 With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err pulse, no data_valid; parity bit 1 -> data_out = 8'h07.

Source files
------------

// File: rtl/mips_uart_rx.sv
// rtl/mips_uart_rx.sv - UART receiver (8 data bits, LSB first, 1 stop) feeding the MIPS input register
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module mips_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_m;
  logic          rx_s;
  logic [1:0]    sync_fill;
  logic          armed;
  logic          res_ok;
  logic          res_ferr;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
  logic          res_perr;
`endif

  // Two-flop synchronizer; sync_fill marks when rx_s carries the real line rather than its reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Frame FSM; results are staged one cycle so output pulses land one clk after the stop sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      armed      <= 1'b0;
      res_ok     <= 1'b0;
      res_ferr   <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      res_perr   <= 1'b0;
`endif
    end else begin
      res_ok     <= 1'b0;
      res_ferr   <= 1'b0;
      data_valid <= res_ok;
      frame_err  <= res_ferr;
      if (res_ok) data_out <= shreg;
`ifdef UART_RX_PARITY_EN
      res_perr   <= 1'b0;
      parity_err <= res_perr;
`else
      parity_err <= 1'b0;
`endif

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
          // After a frame (or reset) the line must be seen high before a new start bit counts
          if (!armed) begin
            if (rx_s && sync_fill[1]) armed <= 1'b1;
          end else if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == FULL_CNT) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_CNT) begin
            cnt     <= '0;
            par_bad <= (rx_s != (^shreg));
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          if (cnt == FULL_CNT) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b0;
            // A bad stop bit takes priority over a parity mismatch
            if (!rx_s) begin
              res_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              res_perr <= 1'b1;
`endif
            end else begin
              res_ok <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_uart_rx.sv
// tb/tb_mips_uart_rx.sv - directed self-checking bench for mips_uart_rx (CLKS_PER_BIT = 8)
`timescale 1ns/1ps
module tb_mips_uart_rx;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Start bit driven after edge N: rx_s low at N+2, START at N+3, start sample N+7,
  // data/parity/stop samples every 8 edges after that, pulse one edge later.
  localparam int DV_LAT = 80 + 8 * PAR;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  mips_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int dv_cyc = 0;
  int pe_cyc = 0;
  int overlap = 0;
  int wide = 0;
  int start_cyc = 0;
  logic dv_q = 1'b0;
  logic fe_q = 1'b0;
  logic pe_q = 1'b0;
  logic [7:0] byte_q[$];

  // Pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      byte_q.push_back(data_out);
    end
    if (frame_err) fe_cnt++;
    if (parity_err) begin
      pe_cnt++;
      pe_cyc = cyc;
    end
    if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1) overlap++;
    if ((data_valid && dv_q) || (frame_err && fe_q) || (parity_err && pe_q)) wide++;
    dv_q = data_valid;
    fe_q = frame_err;
    pe_q = parity_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All drive tasks start and end 1 ns after a rising edge
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? (^d) : ~(^d));
`else
    if (par_ok) begin end
`endif
    drive_bit(stop_bit);
  endtask

  int b_dv, b_fe, b_pe, qb;
  logic [7:0] r81;

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_data_out", data_out, 8'h00);
    check("reset_data_valid", data_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    idle(10);

    // Single frame 0x5A
    b_dv = dv_cnt;
    fork
      send_frame(8'h5A, 1'b1, 1'b1);
      begin
        repeat (40) @(negedge clk);
        check("busy_mid_frame", busy, 1'b1);
      end
    join
    idle(8);
    check("5a_dv_count", dv_cnt - b_dv, 1);
    check("5a_data_out", data_out, 8'h5A);
    check("5a_latency", dv_cyc - start_cyc, DV_LAT);
    check("5a_busy_after", busy, 1'b0);

    // Back-to-back 0x00, 0xFF, 0xA5
    b_dv = dv_cnt;
    qb = byte_q.size();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(8);
    check("b2b_dv_count", dv_cnt - b_dv, 3);
    check("b2b_byte0", byte_q[qb], 8'h00);
    check("b2b_byte1", byte_q[qb + 1], 8'hFF);
    check("b2b_byte2", byte_q[qb + 2], 8'hA5);

    // Start-bit glitch: 3 clks low
    b_dv = dv_cnt;
    b_fe = fe_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    check("glitch_dv", dv_cnt - b_dv, 0);
    check("glitch_fe", fe_cnt - b_fe, 0);
    check("glitch_data_out", data_out, 8'hA5);
    check("glitch_busy", busy, 1'b0);

    // Bad stop bit on 0x3C
    b_dv = dv_cnt;
    b_fe = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(20);
    check("ferr_fe_count", fe_cnt - b_fe, 1);
    check("ferr_dv_count", dv_cnt - b_dv, 0);
    check("ferr_data_out", data_out, 8'hA5);

    // Break: line held low for many frames gives exactly one frame error
    b_dv = dv_cnt;
    b_fe = fe_cnt;
    rx = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    idle(20);
    check("break_fe_count", fe_cnt - b_fe, 1);
    check("break_dv_count", dv_cnt - b_dv, 0);

    // Reset during data bit 5 of 0x81; line stays low through bit 6 before going idle
    b_dv = dv_cnt;
    b_fe = fe_cnt;
    b_pe = pe_cnt;
    r81 = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(r81[i]);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drive_bit(1'b0);
    idle(30);
    check("rst_abort_dv", dv_cnt - b_dv, 0);
    check("rst_abort_fe", fe_cnt - b_fe, 0);
    check("rst_abort_pe", pe_cnt - b_pe, 0);
    check("rst_abort_data_out", data_out, 8'h00);
    b_dv = dv_cnt;
    send_frame(8'h42, 1'b1, 1'b1);
    idle(8);
    check("after_rst_dv", dv_cnt - b_dv, 1);
    check("after_rst_data_out", data_out, 8'h42);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    b_dv = dv_cnt;
    b_pe = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    check("par_bad_pe", pe_cnt - b_pe, 1);
    check("par_bad_dv", dv_cnt - b_dv, 0);
    check("par_bad_latency", pe_cyc - start_cyc, DV_LAT);
    check("par_bad_data_out", data_out, 8'h42);
    b_dv = dv_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    check("par_ok_dv", dv_cnt - b_dv, 1);
    check("par_ok_data_out", data_out, 8'h07);
    b_fe = fe_cnt;
    b_pe = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b0);
    idle(20);
    check("par_and_stop_fe", fe_cnt - b_fe, 1);
    check("par_and_stop_pe", pe_cnt - b_pe, 0);
`else
    check("no_parity_pe_total", pe_cnt, 0);
`endif

    check("pulse_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
